// File: rtl/dvp_frame_buf_sched.sv
// Frame-buffer ring scheduler for the DVP pixel write path: picks the write address per frame,
// gates pixel flow until a buffer is free, and commits/retries frames from the snooped B response.
module dvp_frame_buf_sched #(
  parameter int                    ADDR_W       = 32,
  parameter int                    MST_ID_W     = 5,
  parameter logic [MST_ID_W-1:0]   MST_ID       = 5'h02,
  parameter int                    TRANS_RESP_W = 2,
  parameter int                    BUF_NUM      = 2,
  parameter int                    FRAME_BYTES  = 76800
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_en_i,
  input  logic [ADDR_W-1:0]       cfg_base_addr_i,
  input  logic                    buf_release_i,
  input  logic                    irq_clr_i,
  input  logic                    s_awvalid_i,
  input  logic                    s_awready_i,
  input  logic                    s_wvalid_i,
  input  logic                    s_wready_i,
  input  logic                    s_wlast_i,
  input  logic [MST_ID_W-1:0]     s_bid_i,
  input  logic [TRANS_RESP_W-1:0] s_bresp_i,
  input  logic                    s_bvalid_i,
  input  logic                    s_bready_i,
  output logic [ADDR_W-1:0]       pxl_addr_o,
  output logic                    tx_en_o,
  output logic [2:0]              fill_cnt_o,
  output logic [1:0]              rd_idx_o,
  output logic                    frame_done_o,
  output logic                    frame_err_o,
  output logic                    irq_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BUF = 3'd1,
    ARMED    = 3'd2,
    DATA     = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        wr_idx_q, wr_idx_d;
  logic [1:0]        rd_idx_q, rd_idx_d;
  logic [2:0]        fill_q, fill_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              irq_q, irq_d;

  logic aw_hsk, wl_hsk, b_hsk, b_ok;
  logic commit, release_ok, buf_free;

  function automatic logic [1:0] idx_inc(input logic [1:0] idx);
    return (idx == 2'(BUF_NUM - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [ADDR_W-1:0] buf_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [1:0] idx);
    return base + ADDR_W'(FRAME_BYTES) * ADDR_W'(idx);
  endfunction

  assign aw_hsk     = s_awvalid_i & s_awready_i;
  assign wl_hsk     = s_wvalid_i & s_wready_i & s_wlast_i;
  assign b_hsk      = s_bvalid_i & s_bready_i & (s_bid_i == MST_ID);
  assign b_ok       = (s_bresp_i < TRANS_RESP_W'(2));
  assign buf_free   = (fill_q < 3'(BUF_NUM));
  assign release_ok = buf_release_i & (fill_q != 3'd0);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    addr_d   = addr_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    fill_d   = fill_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    irq_d    = irq_q;
    commit   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_en_i) begin
          base_d  = cfg_base_addr_i;
          addr_d  = buf_addr(cfg_base_addr_i, wr_idx_q);
          state_d = buf_free ? ARMED : WAIT_BUF;
        end
      end
      WAIT_BUF: begin
        if (!cfg_en_i)     state_d = IDLE;
        else if (buf_free) state_d = ARMED;
      end
      ARMED: begin
        if (aw_hsk)         state_d = DATA;
        else if (!cfg_en_i) state_d = IDLE;
      end
      DATA: begin
        if (wl_hsk) state_d = RESP;
      end
      RESP: begin
        if (b_hsk) begin
          commit = b_ok;
          err_d  = ~b_ok;
        end
      end
      default: state_d = IDLE;
    endcase

    if (irq_clr_i) irq_d = 1'b0;
    if (commit) begin
      wr_idx_d = idx_inc(wr_idx_q);
      addr_d   = buf_addr(base_q, idx_inc(wr_idx_q));
      done_d   = 1'b1;
      irq_d    = 1'b1;
    end
    if (release_ok) rd_idx_d = idx_inc(rd_idx_q);

    case ({commit, release_ok})
      2'b10:   fill_d = fill_q + 3'd1;
      2'b01:   fill_d = fill_q - 3'd1;
      default: fill_d = fill_q;
    endcase

    // The exit from RESP looks at the occupancy after this cycle's commit/release.
    if (state_q == RESP && b_hsk) begin
      if (!cfg_en_i)                  state_d = IDLE;
      else if (fill_d == 3'(BUF_NUM)) state_d = WAIT_BUF;
      else                            state_d = ARMED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      wr_idx_q <= 2'd0;
      rd_idx_q <= 2'd0;
      fill_q   <= 3'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      fill_q   <= fill_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  assign pxl_addr_o   = addr_q;
  assign tx_en_o      = (state_q == ARMED) || (state_q == DATA);
  assign fill_cnt_o   = fill_q;
  assign rd_idx_o     = rd_idx_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_dvp_frame_buf_sched.sv
// Bench for dvp_frame_buf_sched: directed vector table, hand-written long-frame and reset
// sequences, then randomized traffic checked against a transaction-level reference model.
module tb_dvp_frame_buf_sched;

  localparam int FB  = 76800;
  localparam int BUF = 2;
  localparam int S_IDLE = 0, S_WAIT = 1, S_ARMED = 2, S_DATA = 3, S_RESP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en, buf_release, irq_clr;
  logic [31:0] cfg_base;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [4:0]  bid;
  logic [1:0]  bresp;
  logic [31:0] pxl_addr;
  logic        tx_en, frame_done, frame_err, irq;
  logic [2:0]  fill_cnt;
  logic [1:0]  rd_idx;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          m_state, m_wr, m_rd, m_fill;
  logic [31:0] m_base, m_addr;
  bit          m_done, m_err, m_irq;

  always #5 clk = ~clk;

  dvp_frame_buf_sched dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_en_i(cfg_en), .cfg_base_addr_i(cfg_base),
    .buf_release_i(buf_release), .irq_clr_i(irq_clr),
    .s_awvalid_i(awvalid), .s_awready_i(awready),
    .s_wvalid_i(wvalid), .s_wready_i(wready), .s_wlast_i(wlast),
    .s_bid_i(bid), .s_bresp_i(bresp), .s_bvalid_i(bvalid), .s_bready_i(bready),
    .pxl_addr_o(pxl_addr), .tx_en_o(tx_en), .fill_cnt_o(fill_cnt), .rd_idx_o(rd_idx),
    .frame_done_o(frame_done), .frame_err_o(frame_err), .irq_o(irq)
  );

  typedef struct {
    bit en, rel, clr, aw, wl, b;
    bit [4:0]  bid;
    bit [1:0]  resp;
    bit        tx;
    bit [31:0] addr;
    int        fill, rd;
    bit        done, err, irq;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit en, bit rel, bit clr, bit aw, bit wl, bit b,
                              bit [4:0] id, bit [1:0] resp, bit tx, bit [31:0] addr,
                              int fill, int rd, bit done, bit err, bit irqv);
    vec_t v;
    v.en = en; v.rel = rel; v.clr = clr; v.aw = aw; v.wl = wl; v.b = b;
    v.bid = id; v.resp = resp; v.tx = tx; v.addr = addr; v.fill = fill; v.rd = rd;
    v.done = done; v.err = err; v.irq = irqv;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_wr = 0; m_rd = 0; m_fill = 0;
    m_base = '0; m_addr = '0; m_done = 0; m_err = 0; m_irq = 0;
  endtask

  // Frame-level rules: a frame is a sequence AW -> last W -> own-ID B; OKAY fills a buffer.
  task automatic model_step();
    int  nxt;
    bit  aw, wl, bh, commit, rel;
    nxt    = m_state;
    aw     = awvalid & awready;
    wl     = wvalid & wready & wlast;
    bh     = bvalid & bready & (bid == 5'h02);
    rel    = buf_release && (m_fill > 0);
    commit = 0;
    m_done = 0;
    m_err  = 0;
    case (m_state)
      S_IDLE:  if (cfg_en) begin
                 m_base = cfg_base;
                 m_addr = m_base + 32'(m_wr * FB);
                 nxt = (m_fill < BUF) ? S_ARMED : S_WAIT;
               end
      S_WAIT:  if (!cfg_en) nxt = S_IDLE; else if (m_fill < BUF) nxt = S_ARMED;
      S_ARMED: if (aw) nxt = S_DATA; else if (!cfg_en) nxt = S_IDLE;
      S_DATA:  if (wl) nxt = S_RESP;
      S_RESP:  if (bh) begin
                 if (bresp < 2) commit = 1; else m_err = 1;
               end
      default: nxt = S_IDLE;
    endcase
    m_fill = m_fill + int'(commit) - int'(rel);
    m_rd   = (m_rd + int'(rel)) % BUF;
    if (commit) begin
      m_wr   = (m_wr + 1) % BUF;
      m_addr = m_base + 32'(m_wr * FB);
      m_done = 1;
    end
    m_irq = commit ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
    if (m_state == S_RESP && bh)
      nxt = !cfg_en ? S_IDLE : (m_fill == BUF ? S_WAIT : S_ARMED);
    m_state = nxt;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("pxl_addr", pxl_addr, m_addr);
    chk("tx_en", 32'(tx_en), 32'(m_state == S_ARMED || m_state == S_DATA));
    chk("fill_cnt", 32'(fill_cnt), 32'(m_fill));
    chk("rd_idx", 32'(rd_idx), 32'(m_rd));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle_bus();
    buf_release = 0; irq_clr = 0;
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
    bvalid = 0; bready = 0; bid = 5'h02; bresp = 2'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, pxl_addr, 32'h0);
    chk({tag, "_outs"}, {25'd0, tx_en, fill_cnt, rd_idx, frame_done, frame_err, irq}, 32'h0);
  endtask

  initial begin
    // directed table: base 0x8000_0000, single-beat frames
    add(1,0,0,0,0,0,2,0, 1,32'h8000_0000,0,0,0,0,0); // r0 IDLE -> ARMED
    add(1,0,0,1,0,0,2,0, 1,32'h8000_0000,0,0,0,0,0); // r1 AW
    add(1,0,0,0,1,0,2,0, 0,32'h8000_0000,0,0,0,0,0); // r2 WLAST
    add(1,0,0,0,0,1,3,0, 0,32'h8000_0000,0,0,0,0,0); // r3 foreign ID
    add(1,0,0,0,0,1,2,2, 1,32'h8000_0000,0,0,0,1,0); // r4 SLVERR
    add(1,0,0,1,0,0,2,0, 1,32'h8000_0000,0,0,0,0,0); // r5
    add(1,0,0,0,1,0,2,0, 0,32'h8000_0000,0,0,0,0,0); // r6
    add(1,0,0,0,0,1,2,0, 1,32'h8001_2C00,1,0,1,0,1); // r7 OKAY
    add(1,0,1,1,0,0,2,0, 1,32'h8001_2C00,1,0,0,0,0); // r8 irq clear
    add(1,0,0,0,1,0,2,0, 0,32'h8001_2C00,1,0,0,0,0); // r9
    add(1,0,1,0,0,1,2,1, 0,32'h8000_0000,2,0,1,0,1); // r10 EXOKAY + clr, set wins, full
    add(1,0,0,0,0,0,2,0, 0,32'h8000_0000,2,0,0,0,1); // r11 WAIT_BUF
    add(1,1,0,0,0,0,2,0, 0,32'h8000_0000,1,1,0,0,1); // r12 release
    add(1,0,0,0,0,0,2,0, 1,32'h8000_0000,1,1,0,0,1); // r13 ARMED
    add(1,0,0,1,0,0,2,0, 1,32'h8000_0000,1,1,0,0,1); // r14
    add(1,0,0,0,1,0,2,0, 0,32'h8000_0000,1,1,0,0,1); // r15
    add(1,1,0,0,0,1,2,0, 1,32'h8001_2C00,1,0,1,0,1); // r16 commit+release
    add(1,1,0,0,0,0,2,0, 1,32'h8001_2C00,0,1,0,0,1); // r17 release
    add(1,1,0,0,0,0,2,0, 1,32'h8001_2C00,0,1,0,0,1); // r18 release at 0 ignored
    add(0,0,0,0,0,0,2,0, 0,32'h8001_2C00,0,1,0,0,1); // r19 disable in ARMED
    add(1,0,0,0,0,0,2,0, 1,32'h8001_2C00,0,1,0,0,1); // r20 re-arm on wr_idx 1
    add(1,0,0,1,0,0,2,0, 1,32'h8001_2C00,0,1,0,0,1); // r21
    add(0,0,0,0,0,0,2,0, 1,32'h8001_2C00,0,1,0,0,1); // r22 disable ignored in DATA
    add(0,0,0,0,1,0,2,0, 0,32'h8001_2C00,0,1,0,0,1); // r23
    add(0,0,0,0,0,1,2,0, 0,32'h8000_0000,1,1,1,0,1); // r24 commit then IDLE
    add(0,0,1,0,0,0,2,0, 0,32'h8000_0000,1,1,0,0,0); // r25 irq clear

    rst_n = 0; cfg_en = 0; cfg_base = 32'h8000_0000;
    idle_bus();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #3 rst_n = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      cfg_en = tbl[i].en; buf_release = tbl[i].rel; irq_clr = tbl[i].clr;
      awvalid = tbl[i].aw; awready = tbl[i].aw;
      wvalid = tbl[i].wl; wready = tbl[i].wl; wlast = tbl[i].wl;
      bvalid = tbl[i].b; bready = tbl[i].b; bid = tbl[i].bid; bresp = tbl[i].resp;
      step();
      chk($sformatf("tbl%0d_tx", i), 32'(tx_en), 32'(tbl[i].tx));
      chk($sformatf("tbl%0d_addr", i), pxl_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_fill", i), 32'(fill_cnt), 32'(tbl[i].fill));
      chk($sformatf("tbl%0d_rd", i), 32'(rd_idx), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_done", i), 32'(frame_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_err", i), 32'(frame_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].irq));
    end
    idle_bus();

    // full-length frame: 19200 beats with occasional wready stalls
    cfg_en = 1;
    step();
    awvalid = 1; awready = 1; step(); awvalid = 0; awready = 0;
    for (int b = 0; b < 19200; b++) begin
      wvalid = 1; wready = (b % 97 != 5); wlast = 0;
      if (!wready) begin step(); wready = 1; end
      wlast = (b == 19199);
      step();
    end
    wvalid = 0; wready = 0; wlast = 0;
    chk("long_resp_txen", 32'(tx_en), 32'h0);
    bvalid = 1; bready = 1; bid = 5'h02; bresp = 2'd0; step(); idle_bus();
    chk("long_done", 32'(frame_done), 32'h1);
    chk("long_fill", 32'(fill_cnt), 32'h2);
    chk("long_addr", pxl_addr, 32'h8001_2C00);
    step();
    chk("long_done_pulse", 32'(frame_done), 32'h0);
    chk("long_waitbuf", 32'(tx_en), 32'h0);

    // drain, start a frame, then reset while in DATA
    buf_release = 1; step(); step(); buf_release = 0;
    step(); step();
    awvalid = 1; awready = 1; step(); idle_bus();
    chk("pre_rst_data", 32'(tx_en), 32'h1);
    #2 rst_n = 0;
    #1 chk_all_zero("async_rst");
    @(posedge clk); #1;
    chk_all_zero("rst_edge");
    model_reset();
    #2 rst_n = 1;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      cfg_en      = ($urandom_range(0, 19) != 0);
      cfg_base    = $urandom & 32'hFFFF_FFFC;
      buf_release = ($urandom_range(0, 9) == 0);
      irq_clr     = ($urandom_range(0, 7) == 0);
      awvalid = $urandom_range(0, 1); awready = $urandom_range(0, 1);
      wvalid  = $urandom_range(0, 1); wready  = $urandom_range(0, 1);
      wlast   = ($urandom_range(0, 3) == 0);
      bvalid  = $urandom_range(0, 1); bready  = $urandom_range(0, 1);
      bid     = ($urandom_range(0, 3) == 0) ? 5'h03 : 5'h02;
      bresp   = 2'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
